// File: rtl/matvec_tile_sched.sv
// rtl/matvec_tile_sched.sv - tile scheduler driving a 4-lane matvec core and draining row-pair results
module matvec_tile_sched #(
  parameter int N         = 4,
  parameter int ACC_W     = 16,
  parameter int MEM_DEPTH = 256,
  parameter int TIMEOUT   = 1024,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AW-1:0]           cmd_w_base,
  input  logic [AW-1:0]           cmd_x_base,
  input  logic                    abort,
  output logic                    core_start,
  input  logic                    core_busy,
  input  logic                    core_done,
  output logic [AW-1:0]           w_base_out,
  output logic [AW-1:0]           x_base_out,
  output logic [2:0]              acc_sel_tile,
  output logic                    clear_all,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data,
  output logic [3:0]              res_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int         WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST_T = 3'(N / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_START, S_WAIT, S_DRAIN0, S_DRAIN1, S_FIN
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [2:0]               r_t;
  logic [WD_W-1:0]          r_wdog;
  logic [AW-1:0]            r_w_base_out;
  logic [AW-1:0]            r_x_base_out;
  logic signed [ACC_W-1:0]  r_res_data;
  logic signed [ACC_W-1:0]  r_y1;
  logic [3:0]               r_res_idx;
  logic                     r_cmd_ready;
  logic                     r_clear_all;
  logic                     r_res_valid;
  logic                     r_done;
  logic                     r_busy;
  logic                     r_err;

  logic w_abort;
  logic w_accept;
  logic w_capture;
  logic w_timeout;
  logic w_hs0;
  logic w_next_tile;

  // Pair sum at ACC_W+1 bits, clamped when the two top bits disagree.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  assign w_abort     = abort && (r_state != S_IDLE);
  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_capture   = (r_state == S_WAIT) && core_done && !w_abort;
  assign w_timeout   = (r_state == S_WAIT) && !core_done && !w_abort &&
                       (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_hs0       = (r_state == S_DRAIN0) && res_ready && !w_abort;
  assign w_next_tile = (r_state == S_DRAIN1) && res_ready && !w_abort && (r_t != LAST_T);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_nx = S_CLEAR;
      S_CLEAR:  w_state_nx = S_START;
      S_START:  if (!core_busy) w_state_nx = S_WAIT;
      S_WAIT: begin
        if (core_done) w_state_nx = S_DRAIN0;
        else if (r_wdog == WD_W'(TIMEOUT - 1)) w_state_nx = S_IDLE;
      end
      S_DRAIN0: if (res_ready) w_state_nx = S_DRAIN1;
      S_DRAIN1: if (res_ready) w_state_nx = (r_t == LAST_T) ? S_FIN : S_START;
      S_FIN:    w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
    if (w_abort) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_t          <= '0;
      r_wdog       <= '0;
      r_w_base_out <= '0;
      r_x_base_out <= '0;
      r_res_data   <= '0;
      r_y1         <= '0;
      r_res_idx    <= '0;
      r_cmd_ready  <= 1'b1;
      r_clear_all  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cmd_ready <= (w_state_nx == S_IDLE);
      r_clear_all <= (w_state_nx == S_CLEAR);
      r_res_valid <= (w_state_nx == S_DRAIN0) || (w_state_nx == S_DRAIN1);
      r_done      <= (w_state_nx == S_FIN);
      r_busy      <= (w_state_nx != S_IDLE);
      r_wdog      <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;
      if (w_accept) begin
        r_w_base_out <= cmd_w_base;
        r_x_base_out <= cmd_x_base;
        r_t          <= '0;
        r_err        <= 1'b0;
      end
      if (w_timeout) r_err <= 1'b1;
      // Odd-row result is parked until the even one has been taken.
      if (w_capture) begin
        r_res_data <= sat_add(acc_in_0, acc_in_1);
        r_y1       <= sat_add(acc_in_2, acc_in_3);
        r_res_idx  <= {r_t, 1'b0};
      end
      if (w_hs0) begin
        r_res_data <= r_y1;
        r_res_idx  <= {r_t, 1'b1};
      end
      if (w_next_tile) begin
        r_t          <= r_t + 1'b1;
        r_w_base_out <= r_w_base_out + AW'(N);
      end
    end
  end

  assign core_start   = (r_state == S_START) && !core_busy && !abort && !rst;
  assign cmd_ready    = r_cmd_ready;
  assign clear_all    = r_clear_all;
  assign res_valid    = r_res_valid;
  assign done         = r_done;
  assign busy         = r_busy;
  assign err          = r_err;
  assign w_base_out   = r_w_base_out;
  assign x_base_out   = r_x_base_out;
  assign acc_sel_tile = r_t;
  assign res_data     = r_res_data;
  assign res_idx      = r_res_idx;

endmodule

// File: tb/tb_matvec_tile_sched.sv
// tb/tb_matvec_tile_sched.sv - directed bench for matvec_tile_sched with a 5-cycle core model
module tb_matvec_tile_sched;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         cmd_w_base;
  logic [7:0]         cmd_x_base;
  logic               abort;
  logic               core_start;
  logic               core_busy;
  logic               core_done;
  logic [7:0]         w_base_out;
  logic [7:0]         x_base_out;
  logic [2:0]         acc_sel_tile;
  logic               clear_all;
  logic signed [15:0] acc_in_0, acc_in_1, acc_in_2, acc_in_3;
  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_data;
  logic [3:0]         res_idx;
  logic               busy;
  logic               done;
  logic               err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_clear, n_start, n_done;
  logic [7:0]  starts[$];
  logic [15:0] qd[$];
  logic [3:0]  qi[$];
  int  cd = 0;
  bit  core_en = 1'b1;

  always #5 clk = ~clk;

  matvec_tile_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_w_base(cmd_w_base), .cmd_x_base(cmd_x_base), .abort(abort),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .w_base_out(w_base_out), .x_base_out(x_base_out), .acc_sel_tile(acc_sel_tile),
    .clear_all(clear_all), .acc_in_0(acc_in_0), .acc_in_1(acc_in_1),
    .acc_in_2(acc_in_2), .acc_in_3(acc_in_3), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .err(err)
  );

  // Core model: one-cycle core_done five cycles after each core_start.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) core_done = 1'b1;
    end
    if (core_start && core_en) cd = 5;
  end

  always @(negedge clk) begin
    if (clear_all) n_clear++;
    if (core_start) begin n_start++; starts.push_back(w_base_out); end
    if (done) n_done++;
    if (res_valid && res_ready) begin qd.push_back(res_data); qi.push_back(res_idx); end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    n_clear = 0; n_start = 0; n_done = 0;
    starts.delete(); qd.delete(); qi.delete();
  endtask

  task automatic run_cmd(input logic [7:0] w, input logic [7:0] x);
    cmd_valid = 1'b1; cmd_w_base = w; cmd_x_base = x;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (n_done == 0 && k < bound) begin tick(); k++; end
    chk(tag, 32'(n_done), 32'd1);
  endtask

  task automatic set_acc(input logic [15:0] a0, a1, a2, a3);
    acc_in_0 = a0; acc_in_1 = a1; acc_in_2 = a2; acc_in_3 = a3;
  endtask

  task automatic chk_results(input string tag, input logic [15:0] y0, input logic [15:0] y1);
    chk({tag, "_cnt"}, 32'(qd.size()), 32'd4);
    for (int i = 0; i < 4 && i < qd.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), 32'(qi[i]), 32'(i));
      chk($sformatf("%s_dat%0d", tag, i), 32'(qd[i]), (i % 2 == 0) ? 32'(y0) : 32'(y1));
    end
  endtask

  initial begin
    logic [15:0] hd;
    logic [3:0]  hi;
    int          unstable, k, t_start, t_err;
    rst = 1'b1; cmd_valid = 1'b0; cmd_w_base = '0; cmd_x_base = '0;
    abort = 1'b0; core_busy = 1'b0; res_ready = 1'b1; core_done = 1'b0;
    set_acc(16'd0, 16'd0, 16'd0, 16'd0);
    clr_mon();
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    rst = 1'b0;
    tick();

    // Basic two-tile job.
    clr_mon();
    set_acc(16'd100, 16'd20, -16'sd5, 16'd7);
    run_cmd(8'h10, 8'h40);
    wait_done("t1_done", 200);
    chk("t1_clears", 32'(n_clear), 32'd1);
    chk("t1_starts", 32'(n_start), 32'd2);
    if (starts.size() == 2) begin
      chk("t1_wbase0", 32'(starts[0]), 32'h10);
      chk("t1_wbase1", 32'(starts[1]), 32'h14);
    end
    chk("t1_xbase", 32'(x_base_out), 32'h40);
    chk("t1_tile", 32'(acc_sel_tile), 32'd1);
    chk_results("t1", 16'd120, 16'd2);
    tick(); tick();
    chk("t1_one_done", 32'(n_done), 32'd1);
    chk("t1_idle", 32'(cmd_ready), 32'd1);

    // Saturation in both directions.
    clr_mon();
    set_acc(16'h7fff, 16'h0001, 16'h8000, 16'hffff);
    run_cmd(8'h00, 8'h00);
    wait_done("t2_done", 200);
    chk_results("t2", 16'h7fff, 16'h8000);

    // Backpressure in DRAIN0 for 7 cycles.
    clr_mon();
    set_acc(16'd3, 16'd4, 16'd5, 16'd6);
    res_ready = 1'b0;
    run_cmd(8'h20, 8'h30);
    k = 0;
    while (!res_valid && k < 100) begin tick(); k++; end
    chk("t3_valid", 32'(res_valid), 32'd1);
    hd = res_data; hi = res_idx; unstable = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!res_valid || res_data !== hd || res_idx !== hi) unstable++;
    end
    chk("t3_stable", 32'(unstable), 32'd0);
    chk("t3_held", 32'(hd), 32'd7);
    res_ready = 1'b1;
    wait_done("t3_done", 200);
    chk_results("t3", 16'd7, 16'd11);

    // Watchdog: core never answers.
    clr_mon();
    core_en = 1'b0;
    run_cmd(8'h00, 8'h00);
    k = 0; t_start = -1; t_err = -1;
    while (!err && k < 1200) begin
      if (core_start && t_start < 0) t_start = k;
      tick(); k++;
    end
    t_err = k;
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_latency", 32'(t_err - t_start), 32'd1025);
    chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_done", 32'(n_done), 32'd0);
    core_en = 1'b1;
    run_cmd(8'h00, 8'h00);
    chk("t4_err_clr", 32'(err), 32'd0);
    wait_done("t4_done2", 200);

    // Abort during WAIT of tile 1.
    clr_mon();
    set_acc(16'd1, 16'd1, 16'd1, 16'd1);
    run_cmd(8'h10, 8'h40);
    k = 0;
    while (n_start < 2 && k < 200) begin tick(); k++; end
    chk("t5_second_start", 32'(n_start), 32'd2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_results", 32'(qd.size()), 32'd2);
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_busy_late", 32'(busy), 32'd0);
    chk("t5_starts", 32'(n_start), 32'd2);

    // Reset while stalled in DRAIN1.
    clr_mon();
    res_ready = 1'b0;
    run_cmd(8'h50, 8'h60);
    k = 0;
    while (!res_valid && k < 100) begin tick(); k++; end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t6_drain1_idx", 32'(res_idx), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_res_data", 32'(res_data), 32'd0);
    chk("t6_res_idx", 32'(res_idx), 32'd0);
    chk("t6_wbase", 32'(w_base_out), 32'd0);
    chk("t6_xbase", 32'(x_base_out), 32'd0);
    chk("t6_tile", 32'(acc_sel_tile), 32'd0);
    rst = 1'b0; res_ready = 1'b1;
    tick();
    clr_mon();
    set_acc(16'd2, 16'd2, 16'd9, 16'd1);
    run_cmd(8'h20, 8'h08);
    wait_done("t6_done", 200);
    chk("t6_clears", 32'(n_clear), 32'd1);
    if (starts.size() > 0) chk("t6_wbase0", 32'(starts[0]), 32'h20);
    chk_results("t6", 16'd4, 16'd10);

    // core_busy holds off core_start.
    clr_mon();
    core_busy = 1'b1;
    run_cmd(8'h00, 8'h00);
    for (int i = 0; i < 6; i++) tick();
    chk("t7_withheld", 32'(n_start), 32'd0);
    chk("t7_busy", 32'(busy), 32'd1);
    core_busy = 1'b0;
    wait_done("t7_done", 200);
    chk("t7_starts", 32'(n_start), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
